// File: rtl/core_pkg.sv
// Shared types and field definitions for the SIMT core sequencer.
package core_pkg;

    // Sequencer states; 3 bits cover all eight.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_REQUEST,
        ST_WAIT,
        ST_EXECUTE,
        ST_UPDATE,
        ST_DONE
    } core_state_t;

    // Bit positions inside a 3-bit NZP flag word and the BRnzp condition mask.
    localparam int NZP_N  = 2;
    localparam int NZP_Z  = 1;
    localparam int NZP_P  = 0;
    localparam int NZP_W  = 3;
    localparam int COND_W = 3;

    typedef logic [NZP_W-1:0] nzp_t;

    // A lane takes a branch when any of its flags matches a bit of the condition mask.
    function automatic logic nzp_match(input nzp_t flags, input logic [COND_W-1:0] cond);
        return (flags[NZP_N] & cond[NZP_N]) |
               (flags[NZP_Z] & cond[NZP_Z]) |
               (flags[NZP_P] & cond[NZP_P]);
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational branch resolution: lane 0 decides, other active lanes are
// compared against that decision to flag divergence.
module branch_unit
    import core_pkg::*;
#(
    parameter int THREADS = 4
) (
    input  nzp_t [THREADS-1:0]  nzp,
    input  logic [COND_W-1:0]   condition,
    input  logic [THREADS-1:0]  active_mask,
    output logic                take,
    output logic                disagree
);

    // Resolve lane 0's decision and look for any active lane that differs.
    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        take     = nzp_match(nzp[0], condition);
        disagree = 1'b0;
        for (int t = 1; t < THREADS; t++) begin
            if (active_mask[t] && (nzp_match(nzp[t], condition) != take)) begin
                disagree = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Per-core control sequencer: fetch/decode/request/wait/execute/update FSM
// owning the PC, per-lane NZP flags, the active mask, the LSU wait timeout
// and branch-divergence detection.
module core_sequencer
    import core_pkg::*;
#(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int LSU_TIMEOUT           = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [$clog2(THREADS_PER_BLOCK):0] thread_count,
    output logic                               done,
    output logic                               error,
    output logic                               diverged,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]   pc,
    output logic                               fetch_enable,
    input  logic                               fetch_done,
    input  logic                               is_branch,
    input  logic                               is_cmp,
    input  logic                               is_ldr,
    input  logic                               is_str,
    input  logic                               is_halt,
    input  logic                               writes_rd,
    input  logic [COND_W-1:0]                  condition,
    input  logic [7:0]                         imm8,
    input  logic [3*THREADS_PER_BLOCK-1:0]     alu_nzp,
    input  logic [THREADS_PER_BLOCK-1:0]       lsu_done,
    output logic                               lsu_enable,
    output logic [THREADS_PER_BLOCK-1:0]       active_mask,
    output logic [THREADS_PER_BLOCK-1:0]       reg_write_enable
);

    localparam int T  = THREADS_PER_BLOCK;
    localparam int PW = PROGRAM_MEM_ADDR_BITS;
    localparam int CW = $clog2(LSU_TIMEOUT + 1);

    core_state_t         state;
    core_state_t         next_state;
    nzp_t [T-1:0]        nzp;
    logic [CW-1:0]       wait_cnt;
    logic                is_mem;
    logic                lanes_done;
    logic                timeout_hit;
    logic                take;
    logic                disagree;
    logic [PW-1:0]       branch_target;

    assign is_mem        = is_ldr | is_str;
    assign lanes_done    = ((lsu_done & active_mask) == active_mask);
    assign timeout_hit   = (wait_cnt == CW'(LSU_TIMEOUT - 1));
    assign branch_target = PW'(imm8);

    // Lane t is active when t < thread_count; oversized counts enable every lane.
    always_comb begin
        for (int t = 0; t < T; t++) begin
            active_mask[t] = (t < int'(thread_count));
        end
    end

    branch_unit #(.THREADS(T)) u_branch (
        .nzp         (nzp),
        .condition   (condition),
        .active_mask (active_mask),
        .take        (take),
        .disagree    (disagree)
    );

    // State register; an asserted reset aborts any instruction in flight.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the strobes, all derived from the current state.
    always_comb begin
        next_state       = state;
        fetch_enable     = 1'b0;
        lsu_enable       = 1'b0;
        reg_write_enable = '0;
        done             = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (thread_count == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                fetch_enable = 1'b1;
                if (fetch_done) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: next_state = ST_REQUEST;
            ST_REQUEST: begin
                lsu_enable = is_mem;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (!is_mem || lanes_done) begin
                    next_state = ST_EXECUTE;
                end else if (timeout_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_EXECUTE: next_state = ST_UPDATE;
            ST_UPDATE: begin
                reg_write_enable = writes_rd ? active_mask : '0;
                next_state       = is_halt ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // PC, NZP flags, sticky status bits and the LSU wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            nzp      <= '0;
            error    <= 1'b0;
            diverged <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pc       <= '0;
                        nzp      <= '0;
                        error    <= 1'b0;
                        diverged <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                ST_REQUEST: wait_cnt <= '0;
                ST_WAIT: begin
                    if (is_mem && !lanes_done) begin
                        if (timeout_hit) begin
                            error <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (is_cmp) begin
                        for (int t = 0; t < T; t++) begin
                            if (active_mask[t]) begin
                                nzp[t] <= alu_nzp[NZP_W*t +: NZP_W];
                            end
                        end
                    end
                    if (!is_halt) begin
                        if (is_branch) begin
                            pc <= take ? branch_target : pc + 1'b1;
                            if (disagree) begin
                                diverged <= 1'b1;
                            end
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: stimulus pushes hand-computed expectations
// into queues, a negedge monitor pops and compares when the DUT presents them.
module tb_core_sequencer;

    localparam int T      = 4;
    localparam int PW     = 8;
    localparam int LSU_TO = 6;  // long enough for the staggered LDR, short enough for a quick timeout

    typedef struct packed {
        logic            br;
        logic            cmp;
        logic            ldr;
        logic            str;
        logic            halt;
        logic            wrd;
        logic [2:0]      cond;
        logic [7:0]      imm;
        logic [11:0]     nzp;
        logic [3:0][7:0] lat;      // WAIT cycle on which each lane's lsu_done rises, 0 = never
        logic [3:0]      rwe;      // expected write strobe in UPDATE
        logic [7:0]      next_pc;  // expected pc at the following fetch
        logic            last;     // no fetch follows (halt or timeout)
    } instr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [2:0]        thread_count;
    logic              done, error, diverged;
    logic [PW-1:0]     pc;
    logic              fetch_enable, fetch_done;
    logic              is_branch, is_cmp, is_ldr, is_str, is_halt, writes_rd;
    logic [2:0]        condition;
    logic [7:0]        imm8;
    logic [3*T-1:0]    alu_nzp;
    logic [T-1:0]      lsu_done;
    logic              lsu_enable;
    logic [T-1:0]      active_mask, reg_write_enable;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [7:0] pc_q[$];
    logic [3:0] rwe_q[$];
    logic [1:0] done_q[$];

    core_sequencer #(
        .THREADS_PER_BLOCK     (T),
        .PROGRAM_MEM_ADDR_BITS (PW),
        .LSU_TIMEOUT           (LSU_TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .thread_count     (thread_count),
        .done             (done),
        .error            (error),
        .diverged         (diverged),
        .pc               (pc),
        .fetch_enable     (fetch_enable),
        .fetch_done       (fetch_done),
        .is_branch        (is_branch),
        .is_cmp           (is_cmp),
        .is_ldr           (is_ldr),
        .is_str           (is_str),
        .is_halt          (is_halt),
        .writes_rd        (writes_rd),
        .condition        (condition),
        .imm8             (imm8),
        .alu_nzp          (alu_nzp),
        .lsu_done         (lsu_done),
        .lsu_enable       (lsu_enable),
        .active_mask      (active_mask),
        .reg_write_enable (reg_write_enable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the pc at every fetch, each write strobe, and status at done.
    logic fe_prev = 1'b0;
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (fetch_enable && !fe_prev) begin
                if (pc_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fetch: got pc %0h expected no fetch", pc);
                end else begin
                    check("pc_at_fetch", 32'(pc), 32'(pc_q.pop_front()));
                end
            end
            if (reg_write_enable != '0) begin
                if (rwe_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got %0h expected none", reg_write_enable);
                end else begin
                    check("reg_write_enable", 32'(reg_write_enable), 32'(rwe_q.pop_front()));
                end
            end
            if (done && !done_prev) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done expected running");
                end else begin
                    check("error_diverged_at_done", 32'({error, diverged}), 32'(done_q.pop_front()));
                end
            end
        end
        fe_prev   <= fetch_enable;
        done_prev <= done;
    end

    function automatic instr_t i_alu(input logic wrd, input logic [3:0] rwe, input logic [7:0] next_pc);
        instr_t i = '0;
        i.wrd = wrd; i.rwe = rwe; i.next_pc = next_pc;
        return i;
    endfunction

    function automatic instr_t i_cmp(input logic [11:0] nzp, input logic [7:0] next_pc);
        instr_t i = '0;
        i.cmp = 1'b1; i.nzp = nzp; i.next_pc = next_pc;
        return i;
    endfunction

    function automatic instr_t i_br(input logic [2:0] cond, input logic [7:0] imm, input logic [7:0] next_pc);
        instr_t i = '0;
        i.br = 1'b1; i.cond = cond; i.imm = imm; i.next_pc = next_pc;
        return i;
    endfunction

    function automatic instr_t i_mem(input logic ldr, input logic [3:0][7:0] lat, input logic [3:0] rwe,
                                     input logic [7:0] next_pc, input logic last);
        instr_t i = '0;
        i.ldr = ldr; i.str = ~ldr; i.wrd = ldr; i.lat = lat;
        i.rwe = rwe; i.next_pc = next_pc; i.last = last;
        return i;
    endfunction

    function automatic instr_t i_halt();
        instr_t i = '0;
        i.halt = 1'b1; i.last = 1'b1;
        return i;
    endfunction

    // Drive one instruction through the pipeline with F=1, following the expected state timing.
    task automatic issue(input instr_t i);
        int   n = 0;
        logic mem;
        logic all_done;
        mem      = i.ldr | i.str;
        all_done = 1'b0;
        if (!i.last) pc_q.push_back(i.next_pc);
        if (i.rwe != '0) rwe_q.push_back(i.rwe);
        while (fetch_enable !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("fetch_request", 32'(fetch_enable), 32'd1);
        is_branch = i.br; is_cmp = i.cmp; is_ldr = i.ldr; is_str = i.str;
        is_halt = i.halt; writes_rd = i.wrd; condition = i.cond; imm8 = i.imm;
        alu_nzp = i.nzp; fetch_done = 1'b1;
        step();  // DECODE
        fetch_done = 1'b0;
        check("fetch_dropped", 32'(fetch_enable), 32'd0);
        step();  // REQUEST
        check("lsu_pulse", 32'(lsu_enable), 32'(mem));
        step();  // WAIT 1
        check("lsu_pulse_single", 32'(lsu_enable), 32'd0);
        if (mem) begin
            for (int w = 1; w <= LSU_TO && !all_done; w++) begin
                for (int t = 0; t < T; t++) begin
                    lsu_done[t] = (i.lat[t] != 8'd0) && (int'(i.lat[t]) <= w);
                end
                all_done = 1'b1;
                for (int t = 0; t < T; t++) begin
                    if (t < int'(thread_count) && !lsu_done[t]) all_done = 1'b0;
                end
                step();
            end
            lsu_done = '0;
        end else begin
            step();  // EXECUTE
        end
        if (!mem || all_done) begin
            step();  // UPDATE
            step();  // FETCH or DONE
        end
    endtask

    task automatic begin_block(input logic [2:0] tc, input logic err, input logic div);
        thread_count = tc;
        if (tc != 3'd0) pc_q.push_back(8'h00);
        done_q.push_back({err, div});
        start     = 1'b1;
        start_cyc = cyc;
    endtask

    // Wait for done, check the execution-cycle count, then release start.
    task automatic end_block(input int exp_cycles);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        if (exp_cycles >= 0) check("block_cycles", 32'(cyc - start_cyc - 1), 32'(exp_cycles));
        start = 1'b0;
        step();
        check("done_cleared", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; thread_count = 3'd0; fetch_done = 1'b0;
        is_branch = 1'b0; is_cmp = 1'b0; is_ldr = 1'b0; is_str = 1'b0; is_halt = 1'b0;
        writes_rd = 1'b0; condition = 3'd0; imm8 = 8'd0; alu_nzp = '0; lsu_done = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({done, error, diverged, fetch_enable, lsu_enable,
                                    reg_write_enable, pc, active_mask}), 32'd0);
        reset = 1'b0;
        step();

        // Reset asserted mid-WAIT of an LDR at pc 1 that never completes.
        thread_count = 3'd4;
        pc_q.push_back(8'h00);
        start = 1'b1;
        issue(i_alu(1'b1, 4'hF, 8'h01));
        n = 0;
        while (fetch_enable !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        is_ldr = 1'b1; writes_rd = 1'b1; fetch_done = 1'b1;
        step();
        fetch_done = 1'b0;
        step();
        step();
        step();
        check("pc_before_reset", 32'(pc), 32'h01);
        reset = 1'b1;
        #1;
        check("abort_outputs", 32'({done, error, diverged, fetch_enable, lsu_enable,
                                    reg_write_enable, pc}), 32'd0);
        step();
        check("abort_next_cycle", 32'({fetch_enable, lsu_enable, reg_write_enable, done}), 32'd0);
        is_ldr = 1'b0; writes_rd = 1'b0;
        pc_q.push_back(8'h00);
        done_q.push_back(2'b00);
        reset = 1'b0;
        step();
        check("restart_pc", 32'(pc), 32'h00);
        check("restart_fetch", 32'(fetch_enable), 32'd1);
        issue(i_halt());
        end_block(-1);

        // Three-instruction program ending in halt: 3 x 6 cycles.
        begin_block(3'd4, 1'b0, 1'b0);
        issue(i_alu(1'b1, 4'hF, 8'h01));
        issue(i_alu(1'b0, 4'h0, 8'h02));
        issue(i_halt());
        end_block(18);

        // LDR on two lanes: lane 0 done on WAIT 3, lane 1 on WAIT 5, lanes 2/3 never.
        begin_block(3'd2, 1'b0, 1'b0);
        issue(i_mem(1'b1, {8'd0, 8'd0, 8'd5, 8'd3}, 4'b0011, 8'h01, 1'b0));
        issue(i_halt());
        end_block(16);

        // CMP all lanes zero, BRz 0x20: uniform branch.
        begin_block(3'd4, 1'b0, 1'b0);
        issue(i_cmp(12'b010_010_010_010, 8'h01));
        issue(i_br(3'b010, 8'h20, 8'h20));
        issue(i_halt());
        end_block(18);

        // Lane 1 negative: lane 0 still branches, divergence flagged.
        begin_block(3'd4, 1'b0, 1'b1);
        issue(i_cmp(12'b010_010_100_010, 8'h01));
        issue(i_br(3'b010, 8'h20, 8'h20));
        issue(i_halt());
        end_block(18);

        // Disagreeing lane 3 is inactive with three threads: no divergence.
        begin_block(3'd3, 1'b0, 1'b0);
        issue(i_cmp(12'b100_010_010_010, 8'h01));
        issue(i_br(3'b010, 8'h20, 8'h20));
        issue(i_halt());
        end_block(18);

        // Not-taken BRn, taken BRp to 0xFF, then pc wraps to 0x00.
        begin_block(3'd4, 1'b0, 1'b0);
        issue(i_cmp(12'b001_001_001_001, 8'h01));
        issue(i_br(3'b100, 8'h40, 8'h02));
        issue(i_br(3'b001, 8'hFF, 8'hFF));
        issue(i_alu(1'b1, 4'hF, 8'h00));
        issue(i_halt());
        end_block(30);

        // STR whose lanes never finish: timeout after LSU_TO WAIT cycles.
        begin_block(3'd4, 1'b1, 1'b0);
        issue(i_mem(1'b0, '0, 4'h0, 8'h00, 1'b1));
        end_block(3 + LSU_TO);
        check("error_sticky_in_idle", 32'(error), 32'd1);

        // Zero threads: straight to DONE, status cleared by the new start.
        begin_block(3'd0, 1'b0, 1'b0);
        end_block(0);

        thread_count = 3'd7;
        #1;
        check("mask_saturate", 32'(active_mask), 32'hF);
        thread_count = 3'd2;
        #1;
        check("mask_two", 32'(active_mask), 32'h3);
        thread_count = 3'd1;
        #1;
        check("mask_one", 32'(active_mask), 32'h1);

        step();
        check("pc_queue_drained", 32'(pc_q.size()), 32'd0);
        check("rwe_queue_drained", 32'(rwe_q.size()), 32'd0);
        check("done_queue_drained", 32'(done_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Parametrised per-core control sequencer for the SIMT compute core. It replaces the core's implicit control with an explicit fetch/decode/request/wait/execute/update state machine, and owns the PC, per-thread NZP flags, active-thread mask, memory-wait timeout and branch-divergence detection. It sits between the block dispatcher (start/done) and the core datapath: fetch unit, decoder, per-thread register files, ALUs and LSUs.

## Interface
- THREADS_PER_BLOCK, 4, lanes per core (1..16)
- PROGRAM_MEM_ADDR_BITS, 8, PC width
- LSU_TIMEOUT, 255, max WAIT cycles for a memory op before error (≥1)
- clk  in  1  clock; sole clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  level; begin block execution
- thread_count  in  $clog2(THREADS_PER_BLOCK)+1  active lanes; values above THREADS_PER_BLOCK saturate
- done  out  1  block finished (halt or error)
- error  out  1  sticky; LSU timeout occurred
- diverged  out  1  sticky; active lanes disagreed on a branch
- pc  out  PROGRAM_MEM_ADDR_BITS  current PC
- fetch_enable  out  1  request instruction at pc
- fetch_done  in  1  instruction valid at decoder
- is_branch, is_cmp, is_ldr, is_str, is_halt, writes_rd  in  1 each  decoded controls
- condition  in  3  BRnzp mask {n,z,p}
- imm8  in  8  branch target
- alu_nzp  in  3*THREADS_PER_BLOCK  per-lane compare result
- lsu_done  in  THREADS_PER_BLOCK  per-lane LSU completion
- lsu_enable  out  1  one-cycle LSU start pulse
- active_mask  out  THREADS_PER_BLOCK  bit t = (t < thread_count)
- reg_write_enable  out  THREADS_PER_BLOCK  per-lane register write strobe

## Operation
- States: IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE.
- IDLE: start=1 → pc←0, all NZP←0, error/diverged←0. Go to FETCH, or to DONE if thread_count==0.
- FETCH: fetch_enable=1 until fetch_done=1 → DECODE.
- DECODE: one cycle → REQUEST.
- REQUEST: lsu_enable=1 for this cycle only if is_ldr|is_str → WAIT.
- WAIT, memory op: stay until (lsu_done & active_mask)==active_mask, then EXECUTE. Counter reaching LSU_TIMEOUT → error←1, state DONE.
- WAIT, non-memory op: one cycle.
- EXECUTE: one cycle → UPDATE.
- UPDATE:
  - reg_write_enable=active_mask if writes_rd, else 0.
  - is_cmp: NZP[t]←alu_nzp[t] for active lanes.
  - is_halt → DONE.
  - is_branch: lane t takes the branch if (NZP[t] & condition)!=0. Lane 0 decides; pc←imm8 truncated/zero-extended to PROGRAM_MEM_ADDR_BITS. Any active lane disagreeing with lane 0 sets diverged←1 and execution continues.
  - otherwise pc←pc+1, wrapping mod 2^PROGRAM_MEM_ADDR_BITS; → FETCH.
- DONE: done=1, held until start=0 → IDLE.
- Inactive lanes: never written, never waited on, never affect divergence.
- A start deassertion outside IDLE/DONE is ignored.

## Timing
- Reset: state IDLE; pc, done, error, diverged, fetch_enable, lsu_enable, reg_write_enable, NZP and timeout counter all 0.
- active_mask is combinational from thread_count.
- Reset asserted mid-instruction aborts immediately; no strobes on the following cycle.
- Non-memory instruction: F+5 cycles, where F = cycles in FETCH (≥1).
- Memory instruction: F+4+W cycles, where W = WAIT cycles (≥1).
- reg_write_enable and pc update coincide with the UPDATE cycle; the new pc is visible on the next cycle.
- done rises on the cycle after the halt's UPDATE or the timeout.
- fetch_done arriving on the same cycle fetch_enable rises is valid (F=1).

## Structure
- Shared package core_pkg:
  - state enum core_state_t (3-bit)
  - NZP bit positions
  - condition field width
- Sub-module branch_unit (combinational):
  - inputs: NZP array, condition, active_mask
  - outputs: take (lane 0) and disagree
- Everything else lives in core_sequencer.

## Test plan
- Reset mid-WAIT → all outputs 0 and state IDLE the next cycle; start=1 → pc=0, fetch_enable=1.
- 3-instruction program ending in halt, fetch_done 1 cycle after request, thread_count=4 → done after 3×6=18 cycles; pc increments 0→1→2.
- LDR with thread_count=2, lsu_done lanes 0/1 at +3/+5 cycles, lanes 2/3 never → proceeds after lane 1; reg_write_enable=4'b0011.
- CMP with lane NZP all 3'b010, then BRz imm8=0x20 → pc=0x20, diverged=0; lane 1 NZP=3'b100 → pc=0x20, diverged=1.
- LDR with lsu_done stuck 0, LSU_TIMEOUT=4 → error=1, done=1 after 4 WAIT cycles; start=0 → IDLE.
- thread_count=0 → DONE without fetch; thread_count=7 at THREADS_PER_BLOCK=4 → active_mask=4'b1111; pc=0xFF non-branch → wraps to 0x00.
